role_mem_rd_arb: RTL and testbench

- Round-robin arbiter that shares the role's `m_axi_mem` read channels (AR + R) among NREQ internal read masters inside role_top.
- `m_axi_mem` carries no ID, so R data returns in AR-issue order.
- An order FIFO records the owner of each outstanding burst; R beats are routed to the FIFO head.
- Write channels are not handled by this block.

---
 rtl/role_mem_rd_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_role_mem_rd_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/role_mem_rd_arb.sv
// Round-robin arbiter sharing the role's m_axi_mem AR/R channels among NREQ read masters.
// Optional macro ROLE_MEM_RD_ARB_PERF_EN adds per-requester AR counters and an AR stall counter.
module role_mem_rd_arb #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 48,
  parameter int DATA_W  = 256,
  parameter int MAX_OUT = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NREQ-1:0]        s_arvalid,
  output logic [NREQ-1:0]        s_arready,
  input  logic [NREQ*ADDR_W-1:0] s_araddr,
  input  logic [NREQ*8-1:0]      s_arlen,
  input  logic [NREQ*3-1:0]      s_arsize,
  input  logic [NREQ*2-1:0]      s_arburst,
  output logic [NREQ-1:0]        s_rvalid,
  input  logic [NREQ-1:0]        s_rready,
  output logic [DATA_W-1:0]      s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rlast,
  output logic [ADDR_W-1:0]      m_axi_mem_araddr,
  output logic [7:0]             m_axi_mem_arlen,
  output logic [2:0]             m_axi_mem_arsize,
  output logic [1:0]             m_axi_mem_arburst,
  output logic                   m_axi_mem_arvalid,
  input  logic                   m_axi_mem_arready,
  input  logic [DATA_W-1:0]      m_axi_mem_rdata,
  input  logic [1:0]             m_axi_mem_rresp,
  input  logic                   m_axi_mem_rlast,
  input  logic                   m_axi_mem_rvalid,
  output logic                   m_axi_mem_rready
`ifdef ROLE_MEM_RD_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]     perf_ar_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ar_addr_q, ar_addr_d;
  logic [7:0]         ar_len_q, ar_len_d;
  logic [2:0]         ar_size_q, ar_size_d;
  logic [1:0]         ar_burst_q, ar_burst_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   fifo_q [MAX_OUT];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rr_found_s;
  logic [IDX_W-1:0]   rr_idx_s;
  logic [IDX_W-1:0]   cand_s;
  logic               grant_s;
  logic               push_s;
  logic               pop_s;
  logic               empty_s;
  logic [IDX_W-1:0]   head_s;

  // Round-robin search starting one past the requester last issued on the master port.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_s     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDX_W'((int'(last_grant_q) + k) % NREQ);
      if (!rr_found_s && s_arvalid[cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s;
      end else begin
        rr_idx_s   = rr_idx_s;
      end
    end
  end

  assign grant_s = (state_q == ST_IDLE) && rr_found_s && (count_q < CNT_W'(MAX_OUT));
  assign push_s  = (state_q == ST_ISSUE) && m_axi_mem_arready;

  // AR FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // AR FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) state_d = ST_ISSUE;
        else         state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (m_axi_mem_arready) state_d = ST_IDLE;
        else                   state_d = ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AR FSM outputs: requester accept pulse in the grant cycle, master valid while issuing.
  always_comb begin
    s_arready         = '0;
    m_axi_mem_arvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) s_arready[rr_idx_s] = 1'b1;
        else         s_arready = '0;
      end
      ST_ISSUE: m_axi_mem_arvalid = 1'b1;
      default:  m_axi_mem_arvalid = 1'b0;
    endcase
  end

  // Capture the winner's request payload in the grant cycle only.
  always_comb begin
    ar_addr_d    = ar_addr_q;
    ar_len_d     = ar_len_q;
    ar_size_d    = ar_size_q;
    ar_burst_d   = ar_burst_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    if (grant_s) begin
      ar_addr_d  = s_araddr[int'(rr_idx_s)*ADDR_W +: ADDR_W];
      ar_len_d   = s_arlen[int'(rr_idx_s)*8 +: 8];
      ar_size_d  = s_arsize[int'(rr_idx_s)*3 +: 3];
      ar_burst_d = s_arburst[int'(rr_idx_s)*2 +: 2];
      win_d      = rr_idx_s;
    end else begin
      win_d      = win_q;
    end
    if (push_s) last_grant_d = win_q;
    else        last_grant_d = last_grant_q;
  end

  // AR payload, winner and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_addr_q    <= '0;
      ar_len_q     <= 8'd0;
      ar_size_q    <= 3'd0;
      ar_burst_q   <= 2'd0;
      win_q        <= '0;
      last_grant_q <= IDX_W'(NREQ - 1);
    end else begin
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      ar_size_q    <= ar_size_d;
      ar_burst_q   <= ar_burst_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign m_axi_mem_araddr  = ar_addr_q;
  assign m_axi_mem_arlen   = ar_len_q;
  assign m_axi_mem_arsize  = ar_size_q;
  assign m_axi_mem_arburst = ar_burst_q;

  // R data returns in AR order, so the order-FIFO head owns the current beat.
  assign empty_s          = (count_q == CNT_W'(0));
  assign head_s           = fifo_q[rptr_q];
  assign m_axi_mem_rready = !empty_s && s_rready[head_s];
  assign pop_s            = m_axi_mem_rvalid && m_axi_mem_rready && m_axi_mem_rlast;
  assign s_rdata          = m_axi_mem_rdata;
  assign s_rresp          = m_axi_mem_rresp;
  assign s_rlast          = m_axi_mem_rlast;

  // Per-requester R valid steering.
  always_comb begin
    s_rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (m_axi_mem_rvalid && !empty_s && (int'(head_s) == i)) s_rvalid[i] = 1'b1;
      else                                                     s_rvalid[i] = 1'b0;
    end
  end

  // Order-FIFO occupancy.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Order-FIFO storage and pointers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        fifo_q[wptr_q] <= win_q;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop_s) rptr_q <= rptr_q + PTR_W'(1);
    end
  end

`ifdef ROLE_MEM_RD_ARB_PERF_EN
  logic [NREQ*32-1:0] perf_ar_q;
  logic [31:0]        perf_stall_q;

  // Performance counters: ARs issued per requester and master AR stall cycles.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      perf_ar_q    <= '0;
      perf_stall_q <= 32'd0;
    end else begin
      if (push_s) perf_ar_q[int'(win_q)*32 +: 32] <= perf_ar_q[int'(win_q)*32 +: 32] + 32'd1;
      if (m_axi_mem_arvalid && !m_axi_mem_arready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ar_cnt    = perf_ar_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_role_mem_rd_arb.sv
// Randomized scoreboard bench for role_mem_rd_arb against a queue-based model of the
// arbitration, outstanding-burst ordering and R steering rules.
`timescale 1ns/1ps
module tb_role_mem_rd_arb;
  localparam int NREQ    = 2;
  localparam int ADDR_W  = 48;
  localparam int DATA_W  = 256;
  localparam int MAX_OUT = 8;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [NREQ-1:0]        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NREQ*ADDR_W-1:0] s_araddr;
  logic [NREQ*8-1:0]      s_arlen;
  logic [NREQ*3-1:0]      s_arsize;
  logic [NREQ*2-1:0]      s_arburst;
  logic [DATA_W-1:0]      s_rdata, m_axi_mem_rdata;
  logic [1:0]             s_rresp, m_axi_mem_rresp, m_axi_mem_arburst;
  logic                   s_rlast, m_axi_mem_rlast, m_axi_mem_rvalid, m_axi_mem_rready;
  logic [ADDR_W-1:0]      m_axi_mem_araddr;
  logic [7:0]             m_axi_mem_arlen;
  logic [2:0]             m_axi_mem_arsize;
  logic                   m_axi_mem_arvalid, m_axi_mem_arready;
`ifdef ROLE_MEM_RD_ARB_PERF_EN
  logic [NREQ*32-1:0]     perf_ar_cnt;
  logic [31:0]            perf_stall_cnt;
`endif

  always #5 aclk = ~aclk;

  role_mem_rd_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_axi_mem_araddr(m_axi_mem_araddr), .m_axi_mem_arlen(m_axi_mem_arlen),
    .m_axi_mem_arsize(m_axi_mem_arsize), .m_axi_mem_arburst(m_axi_mem_arburst),
    .m_axi_mem_arvalid(m_axi_mem_arvalid), .m_axi_mem_arready(m_axi_mem_arready),
    .m_axi_mem_rdata(m_axi_mem_rdata), .m_axi_mem_rresp(m_axi_mem_rresp),
    .m_axi_mem_rlast(m_axi_mem_rlast), .m_axi_mem_rvalid(m_axi_mem_rvalid),
    .m_axi_mem_rready(m_axi_mem_rready)
`ifdef ROLE_MEM_RD_ARB_PERF_EN
    , .perf_ar_cnt(perf_ar_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct { int owner; int len; } burst_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; int owner; } ar_t;

  burst_t rq[$];      // bursts accepted by memory, in issue order
  ar_t    arq[$];     // expected master AR payloads
  ar_t    m_pending;
  bit     m_issuing;
  int     m_last;
  int     m_beat;
  int     vectors = 0;
  int     miscompares = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester the rules say wins this cycle, or -1 for no grant.
  function automatic int rr_pick();
    if (m_issuing || rq.size() >= MAX_OUT) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (s_arvalid[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: advances on each rising edge using only bench-driven inputs.
  initial begin : model
    int w;
    m_issuing = 1'b0; m_last = NREQ - 1; m_beat = 0;
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        rq.delete(); arq.delete();
        m_issuing = 1'b0; m_last = NREQ - 1; m_beat = 0;
      end else begin
        w = rr_pick();
        if (m_axi_mem_rvalid && rq.size() > 0 && s_rready[rq[0].owner]) begin
          if (m_beat == rq[0].len) begin
            void'(rq.pop_front());
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
        if (m_issuing) begin
          if (m_axi_mem_arready) begin
            rq.push_back('{owner: m_pending.owner, len: int'(m_pending.len)});
            m_last    = m_pending.owner;
            m_issuing = 1'b0;
          end
        end else if (w >= 0) begin
          m_pending.addr  = s_araddr[w*ADDR_W +: ADDR_W];
          m_pending.len   = s_arlen[w*8 +: 8];
          m_pending.size  = s_arsize[w*3 +: 3];
          m_pending.burst = s_arburst[w*2 +: 2];
          m_pending.owner = w;
          arq.push_back(m_pending);
          m_issuing = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against model state and the scoreboard.
  initial begin : monitor
    int w;
    logic [NREQ-1:0] exp_arready, exp_rvalid;
    logic exp_rready;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        w = rr_pick();
        exp_arready = '0;
        if (w >= 0) exp_arready[w] = 1'b1;
        chk("s_arready", s_arready, exp_arready);
        chk("m_arvalid", m_axi_mem_arvalid, m_issuing);
        if (m_axi_mem_arvalid) begin
          if (arq.size() == 0) begin
            chk("ar_unexpected", m_axi_mem_arvalid, 1'b0);
          end else begin
            chk("m_araddr", m_axi_mem_araddr, arq[0].addr);
            chk("m_arlen", m_axi_mem_arlen, arq[0].len);
            chk("m_arsize", m_axi_mem_arsize, arq[0].size);
            chk("m_arburst", m_axi_mem_arburst, arq[0].burst);
            if (m_axi_mem_arready) void'(arq.pop_front());
          end
        end
        exp_rvalid = '0;
        exp_rready = 1'b0;
        if (rq.size() > 0) begin
          exp_rready = s_rready[rq[0].owner];
          if (m_axi_mem_rvalid) exp_rvalid[rq[0].owner] = 1'b1;
        end
        chk("s_rvalid", s_rvalid, exp_rvalid);
        chk("m_rready", m_axi_mem_rready, exp_rready);
        if (m_axi_mem_rvalid) begin
          chk("s_rdata", s_rdata, m_axi_mem_rdata);
          chk("s_rresp", s_rresp, m_axi_mem_rresp);
          chk("s_rlast", s_rlast, m_axi_mem_rlast);
        end
      end
    end
  end

  // Stimulus: random traffic with a no-return window to hit the outstanding limit,
  // and a reset applied while an AR is stalled on the master port.
  initial begin : stim
    bit hold, did_rst, rst_now;
    aresetn = 1'b0; s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0; m_axi_mem_arready = 1'b0; m_axi_mem_rvalid = 1'b0; m_axi_mem_rlast = 1'b0;
    m_axi_mem_rdata = '0; m_axi_mem_rresp = 2'd0;
    did_rst = 1'b0; rst_now = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_arvalid", m_axi_mem_arvalid, 1'b0);
    chk("rst_araddr", m_axi_mem_araddr, '0);
    chk("rst_arlen", m_axi_mem_arlen, '0);
    chk("rst_rready", m_axi_mem_rready, 1'b0);
    for (int c = 0; c < 1200; c++) begin
      @(posedge aclk);
      #1;
      hold = (c >= 300 && c < 380);
      for (int i = 0; i < NREQ; i++) begin
        s_arvalid[i] = hold ? (i == 0) : ($urandom_range(0, 99) < 55);
        s_araddr[i*ADDR_W +: ADDR_W] = ADDR_W'({$urandom(), $urandom()});
        s_arlen[i*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 15)) : 8'($urandom_range(0, 3));
        s_arsize[i*3 +: 3]  = 3'($urandom_range(0, 7));
        s_arburst[i*2 +: 2] = 2'($urandom_range(0, 3));
        s_rready[i] = ($urandom_range(0, 99) < 75);
      end
      m_axi_mem_arready = hold ? 1'b1 : ($urandom_range(0, 99) < 70);
      for (int j = 0; j < DATA_W / 32; j++) m_axi_mem_rdata[j*32 +: 32] = $urandom();
      m_axi_mem_rresp = 2'($urandom_range(0, 3));
      if (!hold && rq.size() > 0 && $urandom_range(0, 99) < 70) begin
        m_axi_mem_rvalid = 1'b1;
        m_axi_mem_rlast  = (m_beat == rq[0].len);
      end else begin
        m_axi_mem_rvalid = 1'b0;
        m_axi_mem_rlast  = 1'($urandom_range(0, 1));
      end
      if (rst_now) begin
        aresetn   = 1'b1;
        rst_now   = 1'b0;
        s_arvalid = '1;
        m_axi_mem_rvalid = 1'b0;
        @(negedge aclk);
        chk("post_rst_arvalid", m_axi_mem_arvalid, 1'b0);
        chk("post_rst_grant0", s_arready, NREQ'(1));
        chk("post_rst_rready", m_axi_mem_rready, 1'b0);
      end else if (c >= 700 && !did_rst && m_issuing) begin
        m_axi_mem_arready = 1'b0;
        aresetn = 1'b0;
        did_rst = 1'b1;
        rst_now = 1'b1;
      end
    end
    @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
